mem_port_arbiter: RTL and testbench

Shares the single synchronous memory port between instruction fetch and the execute-stage load/store unit. Each cycle it grants at most one requester, drives the memory, and routes the read data back to that requester on the following cycle. Fetch responses are tagged with PC and epoch, and are killed when execute redirects. An anti-starvation counter guarantees fetch progress under sustained data traffic.

---
 rtl/mem_port_arbiter_pkg.sv | 36 +++
 rtl/mem_port_arbiter_if.sv | 46 ++++
 rtl/mem_port_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter_pkg
//
// Shared types for the core's memory-port logic: the machine word, the fetch
// epoch tag, and the request and ownership types used by mem_port_arbiter.
//
//   rvwordT        32-bit machine word (addresses, instructions, data)
//   EpochT         fetch epoch tag; EPOCH_INVALID marks "no fetch request"
//                  on if_epoch and "no redirect" on redirect_epoch
//   MemOwnerT      which requester owns the access currently in flight
//   MEM_BE_ALL     byte enables for a full-word access
//   MemReqT        one memory-port request (address, write flag, data, strobes)
// ----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

   typedef logic [31:0] rvwordT;

   typedef logic [2:0] EpochT;
   localparam EpochT EPOCH_INVALID = 3'd0;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_DATA = 2'd2
   } MemOwnerT;

   localparam logic [3:0] MEM_BE_ALL = 4'hF;

   typedef struct packed {
      rvwordT     addr;
      logic       we;
      rvwordT     wdata;
      logic [3:0] be;
   } MemReqT;

endpackage : mem_port_arbiter_pkg

// File: rtl/mem_port_arbiter_if.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter_if
//
// The single synchronous memory port. The arbiter is the master: it drives
// one access per cycle and receives the read data on the following cycle.
//
//   mem_en     access this cycle
//   mem_we     1 = write, 0 = read
//   mem_addr   word address
//   mem_wdata  write data
//   mem_be     byte enables
//   mem_rdata  read data, valid the cycle after mem_en
//
// Modports:
//   master  the arbiter (drives the request, samples mem_rdata)
//   slave   the memory   (samples the request, drives mem_rdata)
// ----------------------------------------------------------------------------
interface mem_port_arbiter_if;
   import mem_port_arbiter_pkg::*;

   logic       mem_en;
   logic       mem_we;
   rvwordT     mem_addr;
   rvwordT     mem_wdata;
   logic [3:0] mem_be;
   rvwordT     mem_rdata;

   modport master (
      output mem_en,
      output mem_we,
      output mem_addr,
      output mem_wdata,
      output mem_be,
      input  mem_rdata
   );

   modport slave (
      input  mem_en,
      input  mem_we,
      input  mem_addr,
      input  mem_wdata,
      input  mem_be,
      output mem_rdata
   );

endinterface : mem_port_arbiter_if

// File: rtl/mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the single memory port between instruction fetch and the execute
// stage load/store unit. Each cycle at most one requester is granted; the
// access is driven the same cycle and its read data is routed back to the
// owner on the next cycle. Data normally wins contention, but after
// DATA_BURST_MAX consecutive contended data grants fetch is forced through so
// it always makes progress. Fetch responses carry their pc and epoch and are
// dropped when execute redirects, either in the grant cycle or in the
// response cycle.
//
// Parameters:
//   DATA_BURST_MAX  contended data grants allowed before fetch wins (1..15)
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   if_pc/if_epoch  fetch request (if_epoch == EPOCH_INVALID: no request)
//   if_stall        fetch is requesting but was not granted this cycle
//   if_rsp_*        fetch response (data passes through from mem_rdata)
//   redirect_epoch  execute redirect this cycle when != EPOCH_INVALID
//   d_req/d_we/d_addr/d_wdata/d_be   load/store request
//   d_gnt           load/store accepted this cycle
//   d_rsp_valid/d_rsp_data           load data, or zero as a store ack
//   mem             memory port (master side)
// ----------------------------------------------------------------------------
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned DATA_BURST_MAX = 3
) (
   input  logic       clk,
   input  logic       rst,

   // instruction fetch
   input  rvwordT     if_pc,
   input  EpochT      if_epoch,
   output logic       if_stall,
   output logic       if_rsp_valid,
   output rvwordT     if_rsp_data,
   output rvwordT     if_rsp_pc,
   output EpochT      if_rsp_epoch,

   // execute redirect
   input  EpochT      redirect_epoch,

   // load/store unit
   input  logic       d_req,
   input  logic       d_we,
   input  rvwordT     d_addr,
   input  rvwordT     d_wdata,
   input  logic [3:0] d_be,
   output logic       d_gnt,
   output logic       d_rsp_valid,
   output rvwordT     d_rsp_data,

   // memory port
   mem_port_arbiter_if.master mem
);

   localparam logic [3:0] BURST_LIMIT = 4'(DATA_BURST_MAX);

   logic       if_req;
   logic       redirect;
   logic       burst_full;
   logic       fetch_grant;
   logic       data_grant;
   logic [3:0] burst_cnt;
   logic [3:0] burst_cnt_nxt;
   MemReqT     mem_req;

   // In-flight access, one deep: who owns the data returning next cycle.
   MemOwnerT   rsp_owner;
   MemOwnerT   rsp_owner_nxt;
   rvwordT     rsp_pc;
   EpochT      rsp_epoch;
   logic       rsp_is_store;
   logic       rsp_kill;

   assign if_req     = (if_epoch != EPOCH_INVALID);
   assign redirect   = (redirect_epoch != EPOCH_INVALID);
   assign burst_full = (burst_cnt == BURST_LIMIT);

   // ---------------------------------------------------------------------
   // Arbitration. Grants are held off while rst is high so nothing reaches
   // the memory during reset; if_stall then simply follows if_req.
   // ---------------------------------------------------------------------
   // NOTE: every signal assigned in an always_comb gets a default on the
   // first lines, so no path through the block can leave it holding a value
   // (which would infer a latch).
   always_comb begin
      fetch_grant = 1'b0;
      data_grant  = 1'b0;
      if (!rst) begin
         if (if_req && (!d_req || burst_full)) begin
            fetch_grant = 1'b1;
         end else if (d_req) begin
            data_grant = 1'b1;
         end
      end
   end

   assign if_stall = if_req & ~fetch_grant;
   assign d_gnt    = data_grant;

   // ---------------------------------------------------------------------
   // Memory request mux. Loads always read the full word; only stores use
   // the caller's byte enables.
   // ---------------------------------------------------------------------
   always_comb begin
      mem_req = '{addr: '0, we: 1'b0, wdata: '0, be: '0};
      if (fetch_grant) begin
         mem_req = '{addr: if_pc, we: 1'b0, wdata: '0, be: MEM_BE_ALL};
      end else if (data_grant) begin
         mem_req = '{addr:  d_addr,
                     we:    d_we,
                     wdata: d_wdata,
                     be:    d_we ? d_be : MEM_BE_ALL};
      end
   end

   assign mem.mem_en    = fetch_grant | data_grant;
   assign mem.mem_we    = mem_req.we;
   assign mem.mem_addr  = mem_req.addr;
   assign mem.mem_wdata = mem_req.wdata;
   assign mem.mem_be    = mem_req.be;

   // ---------------------------------------------------------------------
   // Anti-starvation counter: counts data grants that fetch lost. Only
   // contended data grants count; uncontended traffic never pushes fetch
   // toward a forced grant.
   // ---------------------------------------------------------------------
   always_comb begin
      burst_cnt_nxt = burst_cnt;
      if (fetch_grant) begin
         burst_cnt_nxt = '0;
      end else if (data_grant && if_req && !burst_full) begin
         burst_cnt_nxt = burst_cnt + 4'd1;
      end
   end

   // ---------------------------------------------------------------------
   // Owner of next cycle's read data.
   // ---------------------------------------------------------------------
   always_comb begin
      rsp_owner_nxt = OWN_NONE;
      if (fetch_grant) begin
         rsp_owner_nxt = OWN_IF;
      end else if (data_grant) begin
         rsp_owner_nxt = OWN_DATA;
      end
   end

   // ---------------------------------------------------------------------
   // State registers. Async reset clears the owner, which is what drops an
   // access that was in flight when reset hit.
   // ---------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         burst_cnt    <= '0;
         rsp_owner    <= OWN_NONE;
         rsp_pc       <= '0;
         rsp_epoch    <= EPOCH_INVALID;
         rsp_is_store <= 1'b0;
         rsp_kill     <= 1'b0;
      end else begin
         burst_cnt <= burst_cnt_nxt;
         rsp_owner <= rsp_owner_nxt;
         if (fetch_grant) begin
            rsp_pc    <= if_pc;
            rsp_epoch <= if_epoch;
            // The read still happens; only its response is discarded.
            rsp_kill  <= redirect;
         end
         if (data_grant) begin
            rsp_is_store <= d_we;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Responses. A redirect arriving in the response cycle also kills the
   // returning instruction, since it belongs to the old path. Data
   // responses ignore redirects entirely.
   // ---------------------------------------------------------------------
   assign if_rsp_valid = (rsp_owner == OWN_IF) & ~rsp_kill & ~redirect;
   assign if_rsp_data  = mem.mem_rdata;
   assign if_rsp_pc    = rsp_pc;
   assign if_rsp_epoch = rsp_epoch;

   assign d_rsp_valid  = (rsp_owner == OWN_DATA);
   assign d_rsp_data   = (rsp_owner == OWN_DATA && rsp_is_store) ? '0 : mem.mem_rdata;

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter. A memory model returns a known word
// per address one cycle after each read. A transaction-level model tracks the
// contended-data streak and the single access in flight; one compare process
// checks every output against it on each falling edge. Directed steps add
// literal expectations (grant patterns, pcs, epochs) that pin the model.
// ----------------------------------------------------------------------------
module tb_mem_port_arbiter;
   import mem_port_arbiter_pkg::*;

   localparam int unsigned BURST = 3;

   logic       clk = 1'b0;
   logic       rst;
   rvwordT     if_pc;
   EpochT      if_epoch;
   logic       if_stall;
   logic       if_rsp_valid;
   rvwordT     if_rsp_data;
   rvwordT     if_rsp_pc;
   EpochT      if_rsp_epoch;
   EpochT      redirect_epoch;
   logic       d_req;
   logic       d_we;
   rvwordT     d_addr;
   rvwordT     d_wdata;
   logic [3:0] d_be;
   logic       d_gnt;
   logic       d_rsp_valid;
   rvwordT     d_rsp_data;

   int tests = 0;
   int fails = 0;

   mem_port_arbiter_if mem_bus ();

   mem_port_arbiter #(.DATA_BURST_MAX(BURST)) dut (
      .clk           (clk),
      .rst           (rst),
      .if_pc         (if_pc),
      .if_epoch      (if_epoch),
      .if_stall      (if_stall),
      .if_rsp_valid  (if_rsp_valid),
      .if_rsp_data   (if_rsp_data),
      .if_rsp_pc     (if_rsp_pc),
      .if_rsp_epoch  (if_rsp_epoch),
      .redirect_epoch(redirect_epoch),
      .d_req         (d_req),
      .d_we          (d_we),
      .d_addr        (d_addr),
      .d_wdata       (d_wdata),
      .d_be          (d_be),
      .d_gnt         (d_gnt),
      .d_rsp_valid   (d_rsp_valid),
      .d_rsp_data    (d_rsp_data),
      .mem           (mem_bus)
   );

   always #5 clk = ~clk;

   // Memory contents are a fixed function of the address.
   function automatic rvwordT mem_word(rvwordT a);
      return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
   endfunction

   always @(posedge clk) begin
      if (mem_bus.mem_en && !mem_bus.mem_we)
         mem_bus.mem_rdata <= mem_word(mem_bus.mem_addr);
      else
         mem_bus.mem_rdata <= 32'hDEAD_BEEF;
   end

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // ------------------------------------------------------------------
   // Behavioural model
   //   streak: data grants won against a waiting fetch since fetch last ran
   //   prev_*: the one access issued last cycle (kind 0 none, 1 fetch, 2 data)
   // ------------------------------------------------------------------
   int     streak;
   int     prev_kind;
   rvwordT prev_pc;
   EpochT  prev_epoch;
   bit     prev_kill;
   bit     prev_store;
   rvwordT prev_addr;

   function automatic bit want_fetch();
      return if_epoch != EPOCH_INVALID;
   endfunction

   function automatic bit exp_fetch();
      return !rst && want_fetch() && (!d_req || streak >= int'(BURST));
   endfunction

   function automatic bit exp_data();
      return !rst && d_req && !exp_fetch();
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         streak    = 0;
         prev_kind = 0;
      end else begin
         if (exp_fetch()) begin
            prev_kind  = 1;
            prev_pc    = if_pc;
            prev_epoch = if_epoch;
            prev_kill  = (redirect_epoch != EPOCH_INVALID);
            streak     = 0;
         end else if (exp_data()) begin
            prev_kind  = 2;
            prev_store = d_we;
            prev_addr  = d_addr;
            if (want_fetch() && streak < int'(BURST)) streak = streak + 1;
         end else begin
            prev_kind = 0;
         end
      end
   end

   // ------------------------------------------------------------------
   // Compare process: all outputs, every cycle.
   // ------------------------------------------------------------------
   always @(negedge clk) begin
      bit ef, ed, eifv, edv;
      ef = exp_fetch();
      ed = exp_data();
      check("mem_en", 32'(mem_bus.mem_en), 32'(ef | ed));
      check("d_gnt", 32'(d_gnt), 32'(ed));
      check("if_stall", 32'(if_stall), 32'(want_fetch() && !ef));
      if (ef) begin
         check("f_mem_addr", mem_bus.mem_addr, if_pc);
         check("f_mem_we", 32'(mem_bus.mem_we), 32'd0);
         check("f_mem_be", 32'(mem_bus.mem_be), 32'hF);
      end else if (ed) begin
         check("d_mem_addr", mem_bus.mem_addr, d_addr);
         check("d_mem_we", 32'(mem_bus.mem_we), 32'(d_we));
         check("d_mem_be", 32'(mem_bus.mem_be), d_we ? 32'(d_be) : 32'hF);
         if (d_we) check("d_mem_wdata", mem_bus.mem_wdata, d_wdata);
      end else begin
         check("idle_mem_we", 32'(mem_bus.mem_we), 32'd0);
      end

      eifv = (prev_kind == 1) && !prev_kill && (redirect_epoch == EPOCH_INVALID);
      edv  = (prev_kind == 2);
      check("if_rsp_valid", 32'(if_rsp_valid), 32'(eifv));
      check("d_rsp_valid", 32'(d_rsp_valid), 32'(edv));
      if (eifv) begin
         check("if_rsp_pc", if_rsp_pc, prev_pc);
         check("if_rsp_epoch", 32'(if_rsp_epoch), 32'(prev_epoch));
         check("if_rsp_data", if_rsp_data, mem_word(prev_pc));
      end
      if (edv) check("d_rsp_data", d_rsp_data, prev_store ? 32'd0 : mem_word(prev_addr));
   end

   // ------------------------------------------------------------------
   // Stimulus helpers
   // ------------------------------------------------------------------
   task automatic drive(rvwordT pc, EpochT ep, EpochT rd, logic dr, logic we,
                        rvwordT a, rvwordT wd, logic [3:0] be);
      if_pc          = pc;
      if_epoch       = ep;
      redirect_epoch = rd;
      d_req          = dr;
      d_we           = we;
      d_addr         = a;
      d_wdata        = wd;
      d_be           = be;
   endtask

   task automatic idle();
      drive(32'h0, EPOCH_INVALID, EPOCH_INVALID, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Both sides request every cycle; records which cycles fetch won.
   task automatic run_contended(int n, output logic [7:0] fmask, output int stalls);
      fmask  = '0;
      stalls = 0;
      for (int i = 0; i < n; i++) begin
         drive(32'h300 + 32'(4 * i), 3'd1, EPOCH_INVALID, 1'b1, 1'b0,
               32'h4000 + 32'(4 * i), 32'h0, 4'h0);
         @(negedge clk);
         fmask[i] = mem_bus.mem_en & ~d_gnt;
         if (if_stall) stalls++;
         step();
      end
   endtask

   logic [7:0] fmask;
   int         stalls;

   initial begin
      rst = 1'b1;
      drive(32'h0, 3'd1, EPOCH_INVALID, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);

      // reset outputs
      @(negedge clk);
      check("rst_mem_en", 32'(mem_bus.mem_en), 32'd0);
      check("rst_d_gnt", 32'(d_gnt), 32'd0);
      check("rst_if_stall", 32'(if_stall), 32'd1);
      check("rst_if_rsp_pc", if_rsp_pc, 32'd0);
      check("rst_if_rsp_epoch", 32'(if_rsp_epoch), 32'(EPOCH_INVALID));
      step();
      idle();
      rst = 1'b0;
      step();

      // fetch only
      drive(32'h100, 3'd1, EPOCH_INVALID, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      @(negedge clk);
      check("t1_mem_addr", mem_bus.mem_addr, 32'h100);
      check("t1_mem_en", 32'(mem_bus.mem_en), 32'd1);
      step();
      idle();
      @(negedge clk);
      check("t1_rsp_valid", 32'(if_rsp_valid), 32'd1);
      check("t1_rsp_pc", if_rsp_pc, 32'h100);
      check("t1_rsp_epoch", 32'(if_rsp_epoch), 32'd1);
      check("t1_rsp_data", if_rsp_data, mem_word(32'h100));
      step();

      // load then store
      drive(32'h0, EPOCH_INVALID, EPOCH_INVALID, 1'b1, 1'b0, 32'h2000, 32'h0, 4'h0);
      @(negedge clk);
      check("t2_d_gnt", 32'(d_gnt), 32'd1);
      step();
      drive(32'h0, EPOCH_INVALID, EPOCH_INVALID, 1'b1, 1'b1, 32'h2004, 32'hCAFE_F00D, 4'b0011);
      @(negedge clk);
      check("t2_ld_rsp_valid", 32'(d_rsp_valid), 32'd1);
      check("t2_ld_rsp_data", d_rsp_data, mem_word(32'h2000));
      check("t2_st_mem_we", 32'(mem_bus.mem_we), 32'd1);
      check("t2_st_mem_be", 32'(mem_bus.mem_be), 32'b0011);
      step();
      idle();
      @(negedge clk);
      check("t2_st_rsp_valid", 32'(d_rsp_valid), 32'd1);
      check("t2_st_rsp_data", d_rsp_data, 32'd0);
      step();

      // sustained contention: D,D,D,F,D,D,D,F
      run_contended(8, fmask, stalls);
      check("t3_grant_seq", 32'(fmask), 32'b1000_1000);
      check("t3_stall_cycles", 32'(stalls), 32'd6);
      idle();
      step();

      // redirect in the grant cycle
      drive(32'h200, 3'd1, 3'd2, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      step();
      idle();
      @(negedge clk);
      check("t4a_rsp_valid", 32'(if_rsp_valid), 32'd0);
      step();
      // redirect in the response cycle, with a data grant alongside
      drive(32'h204, 3'd1, EPOCH_INVALID, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      step();
      drive(32'h0, EPOCH_INVALID, 3'd2, 1'b1, 1'b0, 32'h2100, 32'h0, 4'h0);
      @(negedge clk);
      check("t4b_rsp_valid", 32'(if_rsp_valid), 32'd0);
      check("t4c_d_gnt_redirect", 32'(d_gnt), 32'd1);
      step();
      idle();
      @(negedge clk);
      check("t4c_d_rsp_valid", 32'(d_rsp_valid), 32'd1);
      step();

      // reset in the cycle after a load grant, with burst_cnt at 3
      run_contended(3, fmask, stalls);
      check("t5_pre_seq", 32'(fmask), 32'b000);
      rst = 1'b1;
      idle();
      @(negedge clk);
      check("t5_rsp_dropped", 32'(d_rsp_valid), 32'd0);
      step();
      rst = 1'b0;
      @(negedge clk);
      check("t5_no_late_rsp", 32'(d_rsp_valid), 32'd0);
      step();
      run_contended(4, fmask, stalls);
      check("t5_burst_cleared", 32'(fmask), 32'b1000);
      idle();
      step();

      // alternating uncontended requests
      drive(32'h0, EPOCH_INVALID, EPOCH_INVALID, 1'b1, 1'b0, 32'h80, 32'h0, 4'h0);
      @(negedge clk);
      check("t6_d_gnt0", 32'(d_gnt), 32'd1);
      step();
      drive(32'h104, 3'd2, EPOCH_INVALID, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      @(negedge clk);
      check("t6_f_addr1", mem_bus.mem_addr, 32'h104);
      check("t6_d_rsp1", 32'(d_rsp_valid), 32'd1);
      step();
      drive(32'h0, EPOCH_INVALID, EPOCH_INVALID, 1'b1, 1'b0, 32'h84, 32'h0, 4'h0);
      @(negedge clk);
      check("t6_d_gnt2", 32'(d_gnt), 32'd1);
      check("t6_if_rsp2", 32'(if_rsp_valid), 32'd1);
      check("t6_if_pc2", if_rsp_pc, 32'h104);
      step();
      drive(32'h108, 3'd2, EPOCH_INVALID, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      @(negedge clk);
      check("t6_d_rsp3", 32'(d_rsp_valid), 32'd1);
      step();
      idle();
      @(negedge clk);
      check("t6_if_pc4", if_rsp_pc, 32'h108);
      step();
      run_contended(4, fmask, stalls);
      check("t6_burst_zero", 32'(fmask), 32'b1000);
      idle();
      step();
      step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_mem_port_arbiter
